// File: rtl/axi4_lite_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_reg_ctrl
// Description : AXI4-Lite slave front end for a register bank. It captures the
//               write address and write data beats independently and holds the
//               read address. A one-bit round-robin pointer chooses between a
//               write and a read when both are ready in the same cycle. Each
//               accepted access issues one single-cycle strobe to the bank.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REG        = 16,
    parameter int AXI_ADDR_WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [AXI_ADDR_WIDTH-1:0]  AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [DATA_WIDTH-1:0]      WDATA,
    input  logic [DATA_WIDTH/8-1:0]    WSTRB,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]  ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [DATA_WIDTH-1:0]      RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [$clog2(NUM_REG)-1:0] REG_ADDR,
    output logic [DATA_WIDTH-1:0]      REG_D,
    output logic                       REG_W_EN,
    output logic                       REG_R_EN,
    input  logic [DATA_WIDTH-1:0]      REG_Q
);

    localparam int c_OFFS  = $clog2(DATA_WIDTH / 8);
    localparam int c_IDX_W = $clog2(NUM_REG);
    localparam logic [AXI_ADDR_WIDTH-1:0] c_NUM_REG_A = AXI_ADDR_WIDTH'(NUM_REG);
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_ACC  = 3'd1;
    localparam logic [2:0] c_WR_RESP = 3'd2;
    localparam logic [2:0] c_RD_ACC  = 3'd3;
    localparam logic [2:0] c_RD_RESP = 3'd4;

    logic [2:0]                state_q, state_d;
    logic                      rr_q;
    logic                      aw_held_q, w_held_q, ar_held_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [DATA_WIDTH-1:0]     w_data_q;
    logic [DATA_WIDTH/8-1:0]   w_strb_q;
    logic [1:0]                bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [c_IDX_W-1:0]        reg_addr_q;
    logic [DATA_WIDTH-1:0]     reg_d_q;
    logic                      reg_w_en_q, reg_w_en_d;
    logic                      reg_r_en_q, reg_r_en_d;

    logic [AXI_ADDR_WIDTH-1:0] w_aw_idx, w_ar_idx;
    logic                      w_aw_legal, w_ar_legal, w_wr_ok;
    logic                      w_grant_wr, w_grant_rd;

    // Address decode: word index plus legality (in range and word aligned)
    assign w_aw_idx   = aw_addr_q >> c_OFFS;
    assign w_ar_idx   = ar_addr_q >> c_OFFS;
    assign w_aw_legal = (w_aw_idx < c_NUM_REG_A) && (aw_addr_q[c_OFFS-1:0] == '0);
    assign w_ar_legal = (w_ar_idx < c_NUM_REG_A) && (ar_addr_q[c_OFFS-1:0] == '0);
    assign w_wr_ok    = w_aw_legal && (&w_strb_q);

    // Arbitration: rr_q=0 favours the write, rr_q=1 favours the read
    assign w_grant_wr = aw_held_q && w_held_q && (!ar_held_q || !rr_q);
    assign w_grant_rd = ar_held_q && (!(aw_held_q && w_held_q) || rr_q);

    assign BRESP    = bresp_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;
    assign REG_ADDR = reg_addr_q;
    assign REG_D    = reg_d_q;
    assign REG_W_EN = reg_w_en_q;
    assign REG_R_EN = reg_r_en_q;

    // State register and round-robin pointer (toggles on every grant)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= c_IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == c_IDLE) && (w_grant_wr || w_grant_rd)) begin
                rr_q <= ~rr_q;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_grant_wr) begin
                    state_d = c_WR_ACC;
                end else if (w_grant_rd) begin
                    state_d = c_RD_ACC;
                end
            end
            c_WR_ACC:  state_d = c_WR_RESP;
            c_WR_RESP: if (BREADY) state_d = c_IDLE;
            c_RD_ACC:  state_d = c_RD_RESP;
            c_RD_RESP: if (RREADY) state_d = c_IDLE;
            default:   state_d = c_IDLE;
        endcase
    end

    // Output decode: channel handshakes and bank strobe requests
    always_comb begin
        AWREADY    = (state_q == c_IDLE) && !aw_held_q;
        WREADY     = (state_q == c_IDLE) && !w_held_q;
        ARREADY    = (state_q == c_IDLE) && !ar_held_q;
        BVALID     = (state_q == c_WR_RESP);
        RVALID     = (state_q == c_RD_RESP);
        reg_w_en_d = (state_q == c_IDLE) && w_grant_wr && w_wr_ok;
        reg_r_en_d = (state_q == c_IDLE) && w_grant_rd && w_ar_legal;
    end

    // Channel holding registers: one beat each, released by the response
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (AWVALID && AWREADY) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= AWADDR;
            end
            if (WVALID && WREADY) begin
                w_held_q <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (ARVALID && ARREADY) begin
                ar_held_q <= 1'b1;
                ar_addr_q <= ARADDR;
            end
            if ((state_q == c_WR_RESP) && BREADY) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
            if ((state_q == c_RD_RESP) && RREADY) begin
                ar_held_q <= 1'b0;
            end
        end
    end

    // Bank interface: strobes last one cycle, address/data hold between accesses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            reg_w_en_q <= 1'b0;
            reg_r_en_q <= 1'b0;
            reg_addr_q <= '0;
            reg_d_q    <= '0;
        end else begin
            reg_w_en_q <= reg_w_en_d;
            reg_r_en_q <= reg_r_en_d;
            if (reg_w_en_d) begin
                reg_addr_q <= w_aw_idx[c_IDX_W-1:0];
                reg_d_q    <= w_data_q;
            end else if (reg_r_en_d) begin
                reg_addr_q <= w_ar_idx[c_IDX_W-1:0];
            end
        end
    end

    // Response registers: fixed before VALID rises, untouched while VALID is high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bresp_q <= c_OKAY;
            rresp_q <= c_OKAY;
            rdata_q <= '0;
        end else begin
            if ((state_q == c_IDLE) && w_grant_wr) begin
                bresp_q <= w_wr_ok ? c_OKAY : c_SLVERR;
            end
            if (state_q == c_RD_ACC) begin
                rdata_q <= w_ar_legal ? REG_Q : '0;
                rresp_q <= w_ar_legal ? c_OKAY : c_SLVERR;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_reg_ctrl
// Description : Directed bench for axi4_lite_reg_ctrl with a strobe/response
//               scoreboard and a small behavioural register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_reg_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  AWADDR, ARADDR;
    logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
    logic        AWREADY, WREADY, ARREADY, BVALID, RVALID;
    logic [31:0] WDATA, RDATA, REG_D, REG_Q;
    logic [3:0]  WSTRB, REG_ADDR;
    logic [1:0]  BRESP, RRESP;
    logic        REG_W_EN, REG_R_EN;

    axi4_lite_reg_ctrl dut (
        .CLK(CLK), .RST(RST),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .REG_ADDR(REG_ADDR), .REG_D(REG_D), .REG_W_EN(REG_W_EN),
        .REG_R_EN(REG_R_EN), .REG_Q(REG_Q)
    );

    always #5 CLK = ~CLK;

    // Register bank model: unwritten entries read as 0x57 + index
    logic [31:0] bank [16];
    logic [15:0] wr_mask = '0;
    always @(posedge CLK) begin
        if (REG_W_EN) begin
            bank[REG_ADDR]    <= REG_D;
            wr_mask[REG_ADDR] <= 1'b1;
        end
    end
    assign REG_Q = wr_mask[REG_ADDR] ? bank[REG_ADDR] : (32'h57 + 32'(REG_ADDR));

    typedef struct packed { logic is_rd; logic [3:0] idx; logic [31:0] data; } strb_t;
    typedef struct packed { logic is_rd; logic [1:0] resp; logic [31:0] data; } resp_t;
    strb_t sq[$];
    resp_t rq[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: strobes and response handshakes, sampled on the falling edge
    strb_t es;
    resp_t er;
    always @(negedge CLK) begin
        if (!RST) begin
            if (REG_W_EN && REG_R_EN) chk("both_strobes", 64'(1), 64'(0));
            if (REG_W_EN || REG_R_EN) begin
                if (sq.size() == 0) begin
                    chk("unexpected_strobe", 64'({REG_W_EN, REG_R_EN}), 64'(0));
                end else begin
                    es = sq.pop_front();
                    chk("strobe_kind", 64'(REG_R_EN), 64'(es.is_rd));
                    chk("strobe_addr", 64'(REG_ADDR), 64'(es.idx));
                    if (!es.is_rd) chk("strobe_data", 64'(REG_D), 64'(es.data));
                end
            end
            if (BVALID && BREADY) begin
                if (rq.size() == 0) begin
                    chk("unexpected_b", 64'(BVALID), 64'(0));
                end else begin
                    er = rq.pop_front();
                    chk("b_order", 64'(er.is_rd), 64'(0));
                    chk("bresp", 64'(BRESP), 64'(er.resp));
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) begin
                    chk("unexpected_r", 64'(RVALID), 64'(0));
                end else begin
                    er = rq.pop_front();
                    chk("r_order", 64'(er.is_rd), 64'(1));
                    chk("rresp", 64'(RRESP), 64'(er.resp));
                    chk("rdata", 64'(RDATA), 64'(er.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_s(input logic rd, input logic [3:0] idx, input logic [31:0] d);
        strb_t s;
        s.is_rd = rd; s.idx = idx; s.data = d;
        sq.push_back(s);
    endtask

    task automatic push_r(input logic rd, input logic [1:0] rsp, input logic [31:0] d);
        resp_t r;
        r.is_rd = rd; r.resp = rsp; r.data = d;
        rq.push_back(r);
    endtask

    // Drives AW and W together; each drops as soon as its own beat is taken
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int k = 0;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        while ((AWVALID || WVALID) && k < 20) begin
            logic aw_t, w_t;
            aw_t = AWVALID && AWREADY;
            w_t  = WVALID && WREADY;
            step();
            if (aw_t) AWVALID = 1'b0;
            if (w_t)  WVALID  = 1'b0;
            k++;
        end
        chk("write_accept_timeout", 64'({AWVALID, WVALID}), 64'(0));
    endtask

    task automatic send_ar(input logic [7:0] a);
        int k = 0;
        ARADDR = a; ARVALID = 1'b1;
        while (!ARREADY && k < 20) begin step(); k++; end
        chk("ar_accept_timeout", 64'(ARREADY), 64'(1));
        step();
        ARVALID = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((rq.size() != 0 || sq.size() != 0) && k < 60) begin step(); k++; end
        chk(tag, 64'(rq.size() + sq.size()), 64'(0));
    endtask

    task automatic wait_valid(input string tag, input logic is_rd);
        int k = 0;
        while (!(is_rd ? RVALID : BVALID) && k < 20) begin step(); k++; end
        chk(tag, 64'(is_rd ? RVALID : BVALID), 64'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bvalid"},  64'(BVALID),   64'(0));
        chk({tag, "_rvalid"},  64'(RVALID),   64'(0));
        chk({tag, "_wen"},     64'(REG_W_EN), 64'(0));
        chk({tag, "_ren"},     64'(REG_R_EN), 64'(0));
        chk({tag, "_rdata"},   64'(RDATA),    64'(0));
        chk({tag, "_regd"},    64'(REG_D),    64'(0));
        chk({tag, "_regaddr"}, 64'(REG_ADDR), 64'(0));
        chk({tag, "_bresp"},   64'(BRESP),    64'(0));
        chk({tag, "_rresp"},   64'(RRESP),    64'(0));
    endtask

    task automatic check_readies(input string tag);
        chk({tag, "_awready"}, 64'(AWREADY), 64'(1));
        chk({tag, "_wready"},  64'(WREADY),  64'(1));
        chk({tag, "_arready"}, 64'(ARREADY), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
        step(); step();
        check_reset_vals("rst0");
        RST = 1'b0;
        step();
        check_readies("rst0_rel");

        // S1: AW and W in the same cycle, exact latency to BVALID
        push_s(1'b0, 4'd2, 32'hDEADBEEF);
        push_r(1'b0, 2'b00, 32'h0);
        axi_write(8'h08, 32'hDEADBEEF, 4'hF);
        chk("s1_bvalid_c0", 64'(BVALID), 64'(0));
        step();
        chk("s1_wen_c1", 64'(REG_W_EN), 64'(1));
        chk("s1_bvalid_c1", 64'(BVALID), 64'(0));
        step();
        chk("s1_bvalid_c2", 64'(BVALID), 64'(1));
        chk("s1_bresp_c2", 64'(BRESP), 64'(0));
        step();
        chk("s1_bvalid_done", 64'(BVALID), 64'(0));
        chk("s1_regaddr_hold", 64'(REG_ADDR), 64'(2));
        chk("s1_regd_hold", 64'(REG_D), 64'(32'hDEADBEEF));

        // S2: W first, AW three cycles later
        WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("s2_wready_held", 64'(WREADY), 64'(0));
            chk("s2_awready_open", 64'(AWREADY), 64'(1));
            chk("s2_no_wen", 64'(REG_W_EN), 64'(0));
            step();
        end
        push_s(1'b0, 4'd4, 32'h12345678);
        push_r(1'b0, 2'b00, 32'h0);
        AWADDR = 8'h10; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        wait_drain("s2_drain");

        // S3: read index 3 with RREADY backpressure
        RREADY = 1'b0;
        push_s(1'b1, 4'd3, 32'h0);
        push_r(1'b1, 2'b00, 32'h5A);
        send_ar(8'h0C);
        wait_valid("s3_rvalid_timeout", 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("s3_rvalid_hold", 64'(RVALID), 64'(1));
            chk("s3_rdata_hold", 64'(RDATA), 64'(32'h5A));
            chk("s3_no_ren", 64'(REG_R_EN), 64'(0));
            step();
        end
        RREADY = 1'b1;
        wait_drain("s3_drain");

        // S4: error cases and range boundaries
        push_r(1'b1, 2'b10, 32'h0);
        send_ar(8'h40);
        wait_drain("s4_ar_oor");
        push_r(1'b0, 2'b10, 32'h0);
        axi_write(8'h04, 32'hCAFEF00D, 4'h3);
        wait_drain("s4_partial_strb");
        push_r(1'b0, 2'b10, 32'h0);
        axi_write(8'h09, 32'hCAFEF00D, 4'hF);
        wait_drain("s4_misaligned");
        push_s(1'b1, 4'd15, 32'h0);
        push_r(1'b1, 2'b00, 32'h66);
        send_ar(8'h3C);
        wait_drain("s4_last_index");
        push_s(1'b1, 4'd1, 32'h0);
        push_r(1'b1, 2'b00, 32'h58);
        send_ar(8'h04);
        wait_drain("s4_idx1_untouched");

        // S5: write and read contending twice after a fresh reset
        RST = 1'b1;
        step();
        check_reset_vals("rst1");
        RST = 1'b0;
        step();
        for (int r = 0; r < 2; r++) begin
            logic [7:0]  wa;
            logic [7:0]  ra;
            logic [31:0] wd;
            logic [31:0] rd_exp;
            wa     = (r == 0) ? 8'h14 : 8'h18;
            wd     = (r == 0) ? 32'hA5A5A5A5 : 32'h11112222;
            ra     = (r == 0) ? 8'h08 : 8'h14;
            rd_exp = (r == 0) ? 32'hDEADBEEF : 32'hA5A5A5A5;
            push_s(1'b0, wa[5:2], wd);
            push_s(1'b1, ra[5:2], 32'h0);
            push_r(1'b0, 2'b00, 32'h0);
            push_r(1'b1, 2'b00, rd_exp);
            AWADDR = wa; WDATA = wd; WSTRB = 4'hF; ARADDR = ra;
            AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
            check_readies("s5_pre");
            step();
            AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
            chk("s5_arready_held", 64'(ARREADY), 64'(0));
            wait_drain("s5_drain");
        end

        // S6: reset while the write response is stalled
        BREADY = 1'b0;
        push_s(1'b0, 4'd7, 32'h77777777);
        axi_write(8'h1C, 32'h77777777, 4'hF);
        wait_valid("s6_bvalid_timeout", 1'b0);
        step();
        chk("s6_bvalid_stall", 64'(BVALID), 64'(1));
        #2;
        RST = 1'b1;
        #1;
        chk("s6_bvalid_async", 64'(BVALID), 64'(0));
        check_reset_vals("s6_rst");
        step();
        RST = 1'b0;
        BREADY = 1'b1;
        step();
        check_readies("s6_rel");
        for (int i = 0; i < 3; i++) begin
            chk("s6_no_bvalid", 64'(BVALID), 64'(0));
            step();
        end
        push_s(1'b1, 4'd7, 32'h0);
        push_r(1'b1, 2'b00, 32'h77777777);
        send_ar(8'h1C);
        wait_drain("s6_recover_read");

        chk("sb_strobe_empty", 64'(sq.size()), 64'(0));
        chk("sb_resp_empty", 64'(rq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
